// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: splits a 4-slot TDM beat stream into lanes a..d.
// Whole frames only; in_sync realigns the stream to slot 0.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_valid     beat on x this cycle
//   in_sync      beat is slot 0 (only when in_valid)
//   x            data beat, W bits
//   a, b, c, d   lane outputs, slots 0..3
//   frame_valid  1-cycle pulse after a frame completes
//   slot         slot the next unsynced beat takes
//   sync_err     1-cycle pulse, sync seen mid-frame
//   frame_cnt    completed frames, mod 256
module tdm_demux_4ch #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_sync,
  input  logic [W-1:0] x,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame_valid,
  output logic [1:0]   slot,
  output logic         sync_err,
  output logic [7:0]   frame_cnt
);

  logic [1:0]   cnt;
  logic [1:0]   e;
  logic         done;
  logic         err_d;
  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic [W-1:0] s2;

  assign slot = cnt;

  always_comb begin
    e     = in_sync ? 2'd0 : cnt;
    done  = in_valid && (e == 2'd3);
    err_d = in_valid && in_sync && (cnt != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 2'd0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= err_d;
      if (in_valid) begin
        unique case (1'b1)
          done: begin
            a           <= s0;
            b           <= s1;
            c           <= s2;
            d           <= x;
            cnt         <= 2'd0;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
          end
          default: begin
            // a sync mid-frame lands here with e=0; stale
            // s1/s2 get rewritten before the frame can close
            unique case (e)
              2'd0:    s0 <= x;
              2'd1:    s1 <= x;
              default: s2 <= x;
            endcase
            cnt <= e + 2'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 SHALL have parameter: W, default 4, lane data width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  beat on x is presented this cycle.
REQ-005 SHALL have port: in_sync  input  1  marks the current beat as slot 0 (frame start); qualified by in_valid.
REQ-006 SHALL have port: x  input  W  serial time-division data beat.
REQ-007 SHALL have ports: a, b, c, d  output  W each  registered lane outputs for slots 0, 1, 2, 3.
REQ-008 SHALL have port: frame_valid  output  1  one-cycle pulse; a..d hold a newly completed frame.
REQ-009 SHALL have port: slot  output  2  slot index the next accepted unsynced beat will occupy.
REQ-010 SHALL have port: sync_err  output  1  one-cycle pulse; sync arrived mid-frame.
REQ-011 SHALL have port: frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-012 SHALL keep an internal 2-bit slot counter cnt, driven onto slot.
REQ-013 SHALL accept a beat on every rising edge with in_valid=1; no backpressure, no stall.
REQ-014 SHALL compute effective slot e = 0 when in_sync=1, else e = cnt, for each accepted beat.
REQ-015 SHALL write x into staging register e for e in {0,1,2}, and set cnt <= e+1.
REQ-016 SHALL, when e=3, load a..d in the same edge from staging 0,1,2 and the current x, then set cnt <= 0 (wrap).
REQ-017 SHALL change a..d only on frame completion (REQ-016); partial frames never appear on the outputs.
REQ-018 SHALL assert frame_valid for exactly the one cycle following the completing edge; back-to-back frames may produce a pulse every 4th cycle.
REQ-019 SHALL increment frame_cnt by 1 on each completing edge, modulo 256.
REQ-020 SHALL pulse sync_err for one cycle when in_valid=1, in_sync=1, and cnt!=0; the partial frame is abandoned and the beat is taken as slot 0.
REQ-021 SHALL ignore in_sync when in_valid=0: no state change, no sync_err.
REQ-022 SHALL hold cnt, staging, and outputs unchanged on cycles with in_valid=0; gaps between beats of one frame are legal.
REQ-023 SHALL treat in_sync=1 with cnt=0 as normal, with no error.
REQ-024 SHALL treat a single beat with in_sync=1 and e=0 as slot 0 only; a frame completes only at e=3.
REQ-025 SHALL use a latency of 0 cycles from the slot-3 beat edge to updated a..d; frame_valid is visible after that edge.

Reset
REQ-026 SHALL, on rst_n low, immediately and asynchronously clear cnt, staging, a..d, frame_valid, sync_err, and frame_cnt to 0.
REQ-027 SHALL discard any in-progress frame when reset asserts mid-frame; the first beat after release is slot 0.
REQ-028 SHALL accept beats from the first rising edge with rst_n high.

Verification
REQ-029 Bench SHALL apply W=4, valid beats 1,2,3,4 on consecutive cycles, first with sync -> a=1, b=2, c=3, d=4; frame_valid high one cycle; frame_cnt=1; slot=0.
REQ-030 Bench SHALL apply beats 5,6 then an in_valid=0 gap of 3 cycles, then 7,8 -> outputs stay 1,2,3,4 during the gap; then a=5, b=6, c=7, d=8; frame_cnt=2.
REQ-031 Bench SHALL apply beats 9,A, then sync with beat B, then C,D,E -> sync_err pulse at the B beat; frame = B,C,D,E; a..d never show 9 or A.
REQ-032 Bench SHALL apply in_sync=1 with in_valid=0 while slot=2 -> no sync_err, slot stays 2.
REQ-033 Bench SHALL apply 256 back-to-back frames -> frame_valid every 4th cycle; frame_cnt wraps to 0 at the 256th frame.
REQ-034 Bench SHALL drop rst_n between clock edges after 2 beats -> all outputs read 0 at once; the next 4 beats after release form a full frame.
